// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution unit: branch-op enum,
// conditional-branch funct3 values and 2-bit history counter states.
package branch_pkg;

    typedef enum logic [1:0] {
        BROP_COND = 2'b00,
        BROP_JAL  = 2'b01,
        BROP_JALR = 2'b10,
        BROP_NONE = 2'b11
    } brop_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Saturating step of a 2-bit history counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up) return (c == ST)  ? ST  : c + 2'd1;
        else    return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one registered update port.
// Only instantiated when BRANCH_PRED_EN is defined.
module branch_bht
    import branch_pkg::*;
#(
    parameter int n           = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] lookup_pc,
    output logic         lookup_pred,
    input  logic         upd_en,
    input  logic [n-1:0] upd_pc,
    input  logic         upd_taken
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0]    cnt [BHT_ENTRIES];
    logic [IW-1:0] lookup_idx;
    logic [IW-1:0] upd_idx;
    logic          unused_pc_bits;

    assign lookup_idx     = lookup_pc[IW+1:2];
    assign upd_idx        = upd_pc[IW+1:2];
    assign unused_pc_bits = ^{lookup_pc[n-1:IW+2], lookup_pc[1:0],
                              upd_pc[n-1:IW+2], upd_pc[1:0]};

    // Read is from the register array, so a same-index update is not visible until next cycle.
    assign lookup_pred = cnt[lookup_idx][1];

    // Counters reset to weakly not-taken and train on resolved conditional branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] <= WNT;
        end else if (upd_en) begin
            cnt[upd_idx] <= ctr_next(cnt[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolution with a one-entry valid/ready
// output register, mispredict detection and statistics counters.
// Optional BHT-based fetch prediction is enabled by defining BRANCH_PRED_EN;
// otherwise fetch_pred is statically not-taken.
module branch_unit
    import branch_pkg::*;
#(
    parameter int n           = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       brop,
    input  logic [2:0]       brfunc,
    input  logic [n-1:0]     A,
    input  logic [n-1:0]     B,
    input  logic [n-1:0]     pc,
    input  logic [n-1:0]     imm,
    input  logic             pred_taken_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [n-1:0]     target,
    output logic [n-1:0]     link,
    output logic             mispredict,
    input  logic [n-1:0]     fetch_pc,
    output logic             fetch_pred,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);
    logic         capture;
    logic         cmp;
    logic         taken_c;
    logic         mis_c;
    logic [n-1:0] target_c;
    logic [n-1:0] jalr_sum;

    assign in_ready = ~out_valid | out_ready;
    assign capture  = in_valid & in_ready;
    assign jalr_sum = A + imm;

    // Conditional compare; the two unused funct3 codes resolve not-taken.
    always_comb begin
        cmp = 1'b0;
        case (brfunc)
            F3_BEQ:  cmp = (A == B);
            F3_BNE:  cmp = (A != B);
            F3_BLT:  cmp = ($signed(A) <  $signed(B));
            F3_BGE:  cmp = ($signed(A) >= $signed(B));
            F3_BLTU: cmp = (A <  B);
            F3_BGEU: cmp = (A >= B);
            default: cmp = 1'b0;
        endcase
    end

    // Direction, target and mispredict; JALR always redirects since no target is predicted.
    always_comb begin
        taken_c  = 1'b0;
        mis_c    = 1'b0;
        target_c = pc + imm;
        case (brop_e'(brop))
            BROP_COND: begin taken_c = cmp;  mis_c = cmp ^ pred_taken_in; end
            BROP_JAL:  begin taken_c = 1'b1; mis_c = ~pred_taken_in;      end
            BROP_JALR: begin
                taken_c  = 1'b1;
                mis_c    = 1'b1;
                target_c = {jalr_sum[n-1:1], 1'b0};
            end
            default:   begin taken_c = 1'b0; mis_c = pred_taken_in;      end
        endcase
    end

    // Output register: load on capture, drop valid on drain, hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            target     <= '0;
            link       <= '0;
            mispredict <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            taken      <= taken_c;
            target     <= target_c;
            link       <= pc + n'(4);
            mispredict <= mis_c;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Statistics counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (capture) begin
            if (brop != BROP_NONE) br_count  <= br_count + 1'b1;
            if (mis_c)             mis_count <= mis_count + 1'b1;
        end
    end

`ifdef BRANCH_PRED_EN
    branch_bht #(
        .n           (n),
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (fetch_pc),
        .lookup_pred (fetch_pred),
        .upd_en      (capture && (brop == BROP_COND)),
        .upd_pc      (pc),
        .upd_taken   (taken_c)
    );
`else
    logic unused_fetch_pc;
    assign unused_fetch_pc = ^fetch_pc;
    assign fetch_pred      = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit; expected values are hand-computed.
// fetch_pred expectations follow whether BRANCH_PRED_EN is defined for the build.
module tb_branch_unit;
    localparam int N  = 32;
    localparam int CW = 16;
`ifdef BRANCH_PRED_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    brop;
    logic [2:0]    brfunc;
    logic [N-1:0]  A, B, pc, imm, target, link, fetch_pc;
    logic          pred_taken_in, taken, mispredict, fetch_pred;
    logic [CW-1:0] br_count, mis_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_unit #(.n(N), .BHT_ENTRIES(16), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .brop(brop), .brfunc(brfunc), .A(A), .B(B), .pc(pc), .imm(imm),
        .pred_taken_in(pred_taken_in), .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .target(target), .link(link), .mispredict(mispredict),
        .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
        .br_count(br_count), .mis_count(mis_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] p, input logic [N-1:0] i, input logic pr);
        in_valid = 1'b1; brop = op; brfunc = f; A = a; B = b;
        pc = p; imm = i; pred_taken_in = pr;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_res(input string tag, input logic t, input logic [N-1:0] tg,
                           input logic m, input int bc, input int mc);
        chk({tag, ".valid"},  out_valid,  1'b1);
        chk({tag, ".taken"},  taken,      t);
        chk({tag, ".target"}, target,     tg);
        chk({tag, ".mis"},    mispredict, m);
        chk({tag, ".brcnt"},  br_count,   bc);
        chk({tag, ".miscnt"}, mis_count,  mc);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fetch_pc = 32'h40;
        drive(2'b11, 3'b000, '0, '0, '0, '0, 1'b0); in_valid = 1'b0;
        #12;
        chk("rst.valid",  out_valid,  1'b0);
        chk("rst.taken",  taken,      1'b0);
        chk("rst.target", target,     '0);
        chk("rst.link",   link,       '0);
        chk("rst.mis",    mispredict, 1'b0);
        chk("rst.brcnt",  br_count,   '0);
        chk("rst.miscnt", mis_count,  '0);
        chk("rst.fpred",  fetch_pred, 1'b0);
        chk("rst.inrdy",  in_ready,   1'b1);
        @(negedge clk); reset = 1'b0;

        // Signed vs unsigned compare of -1 against 1.
        drive(2'b00, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0); tick();
        chk_res("blt", 1'b1, 32'h120, 1'b1, 1, 1);
        chk("blt.link", link, 32'h104);
        drive(2'b00, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0); tick();
        chk_res("bltu", 1'b0, 32'h120, 1'b0, 2, 1);

        // JALR clears bit 0 of A+imm and always mispredicts.
        drive(2'b10, 3'b000, 32'h1003, 32'h0, 32'h100, 32'h4, 1'b1); tick();
        chk_res("jalr", 1'b1, 32'h1006, 1'b1, 3, 2);
        chk("jalr.link", link, 32'h104);

        // Backpressure: pending JAL must wait while the JALR result is held.
        out_ready = 1'b0;
        drive(2'b01, 3'b000, 32'h0, 32'h0, 32'h200, 32'h10, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp.inrdy", in_ready, 1'b0);
            chk_res("bp.hold", 1'b1, 32'h1006, 1'b1, 3, 2);
        end
        out_ready = 1'b1; #1;
        chk("bp.inrdy_up", in_ready, 1'b1);
        tick();
        chk_res("jal", 1'b1, 32'h210, 1'b0, 4, 2);
        chk("jal.link", link, 32'h204);
        in_valid = 1'b0; tick();
        chk("drain.valid", out_valid, 1'b0);
        chk("pre.fpred", fetch_pred, 1'b0);

        // BHT training at pc 0x40: three taken, then two not-taken.
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1); tick();
            chk_res("beq_t", 1'b1, 32'h48, 1'b0, 5 + k, 2);
            chk("beq_t.fpred", fetch_pred, PRED);
        end
        drive(2'b00, 3'b000, 32'h5, 32'h6, 32'h40, 32'h8, 1'b1); tick();
        chk_res("beq_n1", 1'b0, 32'h48, 1'b1, 8, 3);
        chk("beq_n1.fpred", fetch_pred, PRED);
        drive(2'b00, 3'b000, 32'h5, 32'h6, 32'h40, 32'h8, 1'b1); tick();
        chk_res("beq_n2", 1'b0, 32'h48, 1'b1, 9, 4);
        chk("beq_n2.fpred", fetch_pred, 1'b0);

        // Illegal funct3 with equal operands: not-taken, decrements entry to 00.
        drive(2'b00, 3'b010, 32'h7, 32'h7, 32'h40, 32'h8, 1'b1); tick();
        chk_res("ill", 1'b0, 32'h48, 1'b1, 10, 5);
        drive(2'b00, 3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1); tick();
        chk("ill.t1.fpred", fetch_pred, 1'b0);
        drive(2'b00, 3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1); tick();
        chk("ill.t2.fpred", fetch_pred, PRED);
        chk("ill.t2.brcnt", br_count, 12);

        // Non-branch predicted taken.
        drive(2'b11, 3'b000, 32'h0, 32'h0, 32'h300, 32'h8, 1'b1); tick();
        chk_res("nonbr", 1'b0, 32'h308, 1'b1, 12, 6);

        // Reset mid-operation clears result, counters and BHT at once.
        in_valid = 1'b0; out_ready = 1'b0; #2;
        reset = 1'b1; #1;
        chk("mrst.valid",  out_valid,  1'b0);
        chk("mrst.brcnt",  br_count,   '0);
        chk("mrst.miscnt", mis_count,  '0);
        chk("mrst.fpred",  fetch_pred, 1'b0);
        @(negedge clk); reset = 1'b0; out_ready = 1'b1;
        drive(2'b00, 3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b0); tick();
        chk("post.fpred", fetch_pred, PRED);
        chk("post.brcnt", br_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
